fetch_stage: RTL



---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/if_id_reg.sv | 48 ++++
 rtl/fetch_stage.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 16-bit pipelined CPU.
// Contents:
//   - Instruction and opcode widths.
//   - Default reset PC, sequential PC step and bubble encoding.
//   - Opcode constants.
//   - Fetch-stage state encoding.
//   - A helper that extracts the opcode field from an instruction word.
// The bubble encoding uses opcode 0011, which decodes to all-zero controls.
// Opcode 0000 decodes as halt, so it must never be used as a bubble.
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam int OPCODE_W = 4;
   localparam int INSTR_W  = 16;
   localparam int PC_W     = 16;

   localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = 16'h3000;
   localparam logic [PC_W-1:0]    RESET_PC_DEFAULT  = 16'h0000;
   localparam logic [PC_W-1:0]    PC_INC_DEFAULT    = 16'd2;

   localparam logic [OPCODE_W-1:0] OP_HALT = 4'b0000;
   localparam logic [OPCODE_W-1:0] OP_ALU  = 4'b0001;
   localparam logic [OPCODE_W-1:0] OP_ADDI = 4'b0010;
   localparam logic [OPCODE_W-1:0] OP_NOP  = 4'b0011;
   localparam logic [OPCODE_W-1:0] OP_LW   = 4'b0100;
   localparam logic [OPCODE_W-1:0] OP_SW   = 4'b0101;
   localparam logic [OPCODE_W-1:0] OP_BEQ  = 4'b0110;
   localparam logic [OPCODE_W-1:0] OP_JMP  = 4'b0111;

   typedef enum logic {
      FS_RUN    = 1'b0,
      FS_HALTED = 1'b1
   } fetch_state_t;

   // The opcode always occupies the top nibble of the instruction word.
   function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
      return instr[INSTR_W-1 -: OPCODE_W];
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// The IF/ID pipeline register. It holds the fetched instruction, the
// PC+increment of that instruction and a valid flag.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high; loads a bubble
//   load       in   capture next_instr / next_pc and mark the entry valid
//   bubble     in   load the bubble (NOP_INSTR, pc 0, valid 0); overrides load
//   next_instr in   instruction word to capture
//   next_pc    in   PC+increment to capture
//   instr      out  held instruction
//   pc         out  held PC+increment
//   valid      out  0 while a bubble is held
// When neither load nor bubble is asserted, the register holds its contents.
// -----------------------------------------------------------------------------
module if_id_reg
   import cpu_pkg::*;
#(
   parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               bubble,
   input  logic [INSTR_W-1:0] next_instr,
   input  logic [PC_W-1:0]    next_pc,
   output logic [INSTR_W-1:0] instr,
   output logic [PC_W-1:0]    pc,
   output logic               valid
);

   // Reset and bubble both put the register into the same empty state.
   // A bubble wins over load so that a squash can never leak the
   // instruction being fetched into decode.
   always_ff @(posedge clk) begin
      if (reset || bubble) begin
         instr <= NOP_INSTR;
         pc    <= '0;
         valid <= 1'b0;
      end else if (load) begin
         instr <= next_instr;
         pc    <= next_pc;
         valid <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage of the 16-bit pipelined CPU. It owns the PC,
// drives the instruction memory and loads the IF/ID register. It also holds
// a RUN/HALTED state machine: a halt instruction in ID freezes fetch until
// reset.
// Ports:
//   clk           in   rising-edge clock
//   reset         in   synchronous, active-high
//   stall         in   hold PC and IF/ID (load-use hazard)
//   halt          in   halt instruction is in ID
//   if_flush      in   squash the instruction being fetched
//   pc_op         in   redirect the PC this cycle
//   b_jmp         in   redirect source: 1 = branch_target, 0 = jump_target
//   branch_target in   resolved branch address
//   jump_target   in   jump address
//   imem_addr     out  instruction memory address (equals pc)
//   imem_rdata    in   instruction word at imem_addr, same cycle
//   if_id_instr   out  IF/ID instruction
//   if_id_pc      out  IF/ID PC+PC_INC
//   if_id_valid   out  0 while IF/ID holds a bubble
//   id_opcode     out  opcode field of if_id_instr
//   halted        out  1 while in HALTED
// Optional build macro FETCH_PERF_CNT_EN adds these outputs:
//   fetch_count   out  number of normal IF/ID loads (16-bit, wraps)
//   bubble_count  out  number of bubbles inserted by halt, pc_op or if_flush
// -----------------------------------------------------------------------------
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [PC_W-1:0]    RESET_PC  = RESET_PC_DEFAULT,
   parameter logic [PC_W-1:0]    PC_INC    = PC_INC_DEFAULT,
   parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stall,
   input  logic                halt,
   input  logic                if_flush,
   input  logic                pc_op,
   input  logic                b_jmp,
   input  logic [PC_W-1:0]     branch_target,
   input  logic [PC_W-1:0]     jump_target,
   output logic [PC_W-1:0]     imem_addr,
   input  logic [INSTR_W-1:0]  imem_rdata,
   output logic [INSTR_W-1:0]  if_id_instr,
   output logic [PC_W-1:0]     if_id_pc,
   output logic                if_id_valid,
   output logic [OPCODE_W-1:0] id_opcode,
   output logic                halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0]         fetch_count,
   output logic [15:0]         bubble_count
`endif
);

   fetch_state_t    state;
   fetch_state_t    state_next;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] pc_next;
   logic [PC_W-1:0] pc_plus;
   logic            load_if_id;
   logic            bubble_if_id;

   // The sequential PC wraps modulo 2^16 with no overflow indication.
   assign pc_plus   = pc + PC_INC;
   assign imem_addr = pc;

   // State and PC register. Reset has absolute priority over every other
   // input, including while halted.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FS_RUN;
         pc    <= RESET_PC;
      end else begin
         state <= state_next;
         pc    <= pc_next;
      end
   end

   // Next-state, next-PC and IF/ID control.
   // The order of the RUN branches sets the per-cycle priority:
   // halt, redirect, flush, stall, then normal fetch. A redirect deliberately
   // beats stall, because the instruction that stall would protect is
   // being squashed anyway.
   // HALTED ignores every input and keeps loading bubbles. This keeps
   // the halt opcode from reaching decode again.
   always_comb begin
      state_next   = state;
      pc_next      = pc;
      load_if_id   = 1'b0;
      bubble_if_id = 1'b0;
      unique case (state)
         FS_RUN: begin
            if (halt) begin
               state_next   = FS_HALTED;
               bubble_if_id = 1'b1;
            end else if (pc_op) begin
               pc_next      = b_jmp ? branch_target : jump_target;
               bubble_if_id = 1'b1;
            end else if (if_flush) begin
               pc_next      = pc_plus;
               bubble_if_id = 1'b1;
            end else if (!stall) begin
               pc_next      = pc_plus;
               load_if_id   = 1'b1;
            end
         end
         FS_HALTED: begin
            bubble_if_id = 1'b1;
         end
      endcase
   end

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk        (clk),
      .reset      (reset),
      .load       (load_if_id),
      .bubble     (bubble_if_id),
      .next_instr (imem_rdata),
      .next_pc    (pc_plus),
      .instr      (if_id_instr),
      .pc         (if_id_pc),
      .valid      (if_id_valid)
   );

   assign id_opcode = opcode_of(if_id_instr);
   assign halted    = (state == FS_HALTED);

`ifdef FETCH_PERF_CNT_EN
   // Performance counters. Bubbles that HALTED keeps reloading are not
   // counted, so both counters freeze once the core has halted.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_count  <= '0;
         bubble_count <= '0;
      end else begin
         if (load_if_id) begin
            fetch_count <= fetch_count + 16'd1;
         end
         if (bubble_if_id && (state == FS_RUN)) begin
            bubble_count <= bubble_count + 16'd1;
         end
      end
   end
`endif

endmodule
